greater_than_max_tracker: RTL
=============================

Name: greater_than_max_tracker

Overview:
Windowed running-maximum stage placed directly downstream of greater_than_4_bit and driving it. Accepts a stream of NUM_OF_BITS-wide unsigned samples over a valid/ready handshake. Uses the external comparator to decide whether each new sample beats the stored maximum. After WINDOW samples, presents the window maximum and its position through a valid/ready output, then starts a new window.

Parameters:
NUM_OF_BITS, 4, sample and comparator operand width.
WINDOW, 8, samples per window; legal range 1..256.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  NUM_OF_BITS  unsigned sample.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a sample this cycle.
cmp_a  output  NUM_OF_BITS  comparator operand a; driven combinationally equal to in_data.
cmp_b  output  NUM_OF_BITS  comparator operand b; driven combinationally equal to stored max.
cmp_gt  input  1  comparator result, expected to equal (cmp_a > cmp_b), combinational in the same cycle.
max_data  output  NUM_OF_BITS  window maximum.
max_index  output  IDX_W  0-based position of the maximum within the window; IDX_W = max(1, $clog2(WINDOW)).
max_valid  output  1  max_data and max_index are valid.
max_ready  input  1  downstream accepts the result.
busy  output  1  at least one sample of the current window has been accepted.

Behaviour:
- Reset: asynchronous, active-low. When asserted, all registers clear at once: state=FIRST, max=0, index=0, count=0, max_valid=0, busy=0. in_ready is 1 in the first cycle after rst_n deasserts.
- A sample is accepted when in_valid && in_ready at a rising edge of clk. There is no acceptance without valid.
- The comparator path is combinational. cmp_gt is sampled in the same cycle that the sample is accepted. The block has no internal compare logic.
- State machine, three states:
  - FIRST: in_ready=1, busy=0, max_valid=0. On accept: max<=in_data, index<=0, count<=1, busy<=1. If WINDOW==1 go to HOLD, otherwise go to ACCUM. cmp_gt is ignored in this state.
  - ACCUM: in_ready=1, busy=1.
    - On accept, if cmp_gt: max<=in_data and index<=count.
    - On a tie or a smaller sample, max and index are unchanged, so the earliest maximum wins.
    - count<=count+1 on every accept.
    - When the accepted sample is number WINDOW-1 (0-based), go to HOLD.
    - Idle cycles (in_valid=0) change nothing.
  - HOLD: in_ready=0, max_valid=1, busy=1. max_data and max_index are stable while max_valid=1 and max_ready=0. On max_ready: go to FIRST, count<=0, busy<=0, max_valid<=0. max_data and max_index keep their last value after handshake.
- Latency: max_valid rises on the clock edge that accepts the last sample, so it is visible in the following cycle. The earliest new-window accept is the cycle after the output handshake; no sample is accepted in the handshake cycle itself. Back-to-back window throughput is therefore WINDOW+1 cycles.
- Widths:
  - Data is unsigned NUM_OF_BITS.
  - count is IDX_W+1 bits and never exceeds WINDOW.
  - There is no wrap-around inside a window.
- Boundaries:
  - All-equal window: index=0.
  - WINDOW=1: every sample goes FIRST->HOLD.
  - in_valid held high during HOLD: no sample is consumed; the upstream must hold its data.
  - rst_n asserted mid-window or during HOLD: partial window is discarded and max_valid drops immediately.

Test Plan:
- N=4, W=8, samples 1,2,3,4,5,6,7,8 with in_valid continuous and max_ready=1 -> max_data=8, max_index=7, max_valid high for exactly 1 cycle, in the cycle after the 8th accept.
- Samples 15,3,3,0,9,15,2,1 -> max_data=15, max_index=0 (tie keeps earliest). Check cmp_b=15 for every accept after the first.
- Samples 0,0,0,0,0,0,0,0 -> max_data=0, max_index=0. Check cmp_gt is never acting and no update occurs.
- Samples 4,9,2,12,12,5,1,11 with max_ready=0 for 5 cycles -> in_ready=0 and max_data=12, max_index=3 stable all 5 cycles. A sample offered during the stall is not consumed; it becomes sample 0 of the next window after the handshake.
- Random in_valid gaps (~50% duty) over 3 windows, compared against a reference model -> results match and each sample is counted exactly once.
- Reset mid-window: pull rst_n low after 5 accepts -> outputs go to 0 immediately. Afterwards, 8 new samples 7,1,1,1,1,1,1,1 -> max_data=7, max_index=0 with no leftovers from the aborted window.

Source files
------------

// File: rtl/greater_than_max_tracker.sv
// -----------------------------------------------------------------------------
// greater_than_max_tracker
//
// Windowed running-maximum stage. It accepts WINDOW unsigned samples over a
// valid/ready handshake. An external greater_than_4_bit comparator decides
// whether each new sample beats the stored running maximum. After the last
// sample of a window it presents the window maximum and its 0-based position
// over a valid/ready output. A new window starts after that handshake.
//
// Ports
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   in_data    unsigned input sample
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts a sample this cycle
//   cmp_a      comparator operand a, equal to in_data
//   cmp_b      comparator operand b, equal to the stored running maximum
//   cmp_gt     comparator result (cmp_a > cmp_b), same cycle
//   max_data   maximum of the last completed window
//   max_index  0-based position of that maximum (earliest wins on ties)
//   max_valid  max_data / max_index are being offered downstream
//   max_ready  downstream accepts the result
//   busy       at least one sample of the current window has been accepted
// -----------------------------------------------------------------------------
module greater_than_max_tracker #(
    parameter  int NUM_OF_BITS = 4,
    parameter  int WINDOW      = 8,
    localparam int IDX_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_OF_BITS-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NUM_OF_BITS-1:0] cmp_a,
    output logic [NUM_OF_BITS-1:0] cmp_b,
    input  logic                   cmp_gt,
    output logic [NUM_OF_BITS-1:0] max_data,
    output logic [IDX_W-1:0]       max_index,
    output logic                   max_valid,
    input  logic                   max_ready,
    output logic                   busy
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                   state_q,     state_d;
    logic [NUM_OF_BITS-1:0]   run_max_q,   run_max_d;
    logic [IDX_W-1:0]         run_idx_q,   run_idx_d;
    logic [CNT_W-1:0]         count_q,     count_d;
    logic [NUM_OF_BITS-1:0]   max_data_q,  max_data_d;
    logic [IDX_W-1:0]         max_index_q, max_index_d;
    logic                     max_valid_q, max_valid_d;
    logic                     busy_q,      busy_d;
    logic                     in_ready_q,  in_ready_d;

    logic                     accept_s;
    logic [NUM_OF_BITS-1:0]   new_max_s;
    logic [IDX_W-1:0]         new_idx_s;

    // Comparator operands are pure wiring; the comparison itself lives outside.
    assign cmp_a = in_data;
    assign cmp_b = run_max_q;

    assign in_ready  = in_ready_q;
    assign max_data  = max_data_q;
    assign max_index = max_index_q;
    assign max_valid = max_valid_q;
    assign busy      = busy_q;

    assign accept_s = in_valid & in_ready_q;

    // Running maximum after the current sample: the first sample always loads,
    // later samples load only on a strict win, so ties keep the earliest index.
    always_comb begin
        new_max_s = run_max_q;
        new_idx_s = run_idx_q;
        if (state_q == ST_FIRST) begin
            new_max_s = in_data;
            new_idx_s = {IDX_W{1'b0}};
        end else if (cmp_gt) begin
            new_max_s = in_data;
            new_idx_s = count_q[IDX_W-1:0];
        end else begin
            new_max_s = run_max_q;
            new_idx_s = run_idx_q;
        end
    end

    // Next-state and next-output computation for the window FSM.
    always_comb begin
        state_d     = state_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        count_d     = count_q;
        max_data_d  = max_data_q;
        max_index_d = max_index_q;
        max_valid_d = max_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_FIRST: begin
                if (accept_s) begin
                    run_max_d = new_max_s;
                    run_idx_d = new_idx_s;
                    count_d   = CNT_ONE;
                    busy_d    = 1'b1;
                    if (WINDOW == 1) begin
                        state_d     = ST_HOLD;
                        max_data_d  = new_max_s;
                        max_index_d = new_idx_s;
                        max_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_FIRST;
                end
            end

            ST_ACCUM: begin
                if (accept_s) begin
                    run_max_d = new_max_s;
                    run_idx_d = new_idx_s;
                    count_d   = count_q + CNT_ONE;
                    if (count_q == LAST_CNT) begin
                        // Last sample of the window: publish the result now.
                        state_d     = ST_HOLD;
                        max_data_d  = new_max_s;
                        max_index_d = new_idx_s;
                        max_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end

            ST_HOLD: begin
                if (max_ready) begin
                    state_d     = ST_FIRST;
                    count_d     = {CNT_W{1'b0}};
                    busy_d      = 1'b0;
                    max_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d     = ST_FIRST;
                count_d     = {CNT_W{1'b0}};
                busy_d      = 1'b0;
                max_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset discards any partial window at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FIRST;
            run_max_q   <= {NUM_OF_BITS{1'b0}};
            run_idx_q   <= {IDX_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            max_data_q  <= {NUM_OF_BITS{1'b0}};
            max_index_q <= {IDX_W{1'b0}};
            max_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            count_q     <= count_d;
            max_data_q  <= max_data_d;
            max_index_q <= max_index_d;
            max_valid_q <= max_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule
